// File: rtl/dma_burst_sched.sv
// -----------------------------------------------------------------------------
// dma_burst_sched
//
// Two-requester burst scheduler in front of the UART DMA engine. A burst
// command (SRAM base, host base, element count) is taken from one of two
// requesters, chosen round-robin when both are asking. Each element of the
// burst is read from on-chip SRAM (one 18-bit cherry float per word) and
// handed to the DMA engine with a one-cycle we pulse. The next element is not
// started until the engine's busy has risen and fallen again.
//
// Handshake: a command transfers on a cycle where reqN_valid && reqN_ready.
// reqN_ready is combinational, high only in IDLE (and out of reset) for the
// arbitration winner. A requester that is not accepted must hold valid and
// its command fields stable until it is accepted; commands are never dropped.
//
// Ports
//   clk, reset         clock; synchronous active-high reset
//   reqN_valid/ready   command handshake, N = 0, 1
//   reqN_sram_addr     first SRAM word of the burst
//   reqN_host_addr     first host address of the burst
//   reqN_len           element count, 0 legal (completes with no transfers)
//   sram_rd_en/addr    SRAM read strobe and address
//   sram_rd_data       SRAM read data, valid the cycle after sram_rd_en
//   dma_dat_w          float presented to the DMA engine
//   dma_dat_addr       host address presented to the DMA engine
//   dma_we             one-cycle start pulse to the DMA engine
//   dma_busy           DMA engine busy
//   done, done_id      one-cycle burst-complete pulse and its requester
//   active             high whenever the scheduler is not idle
//   state_dbg          current FSM state encoding, for observation
// -----------------------------------------------------------------------------
module dma_burst_sched #(
    parameter int SRAM_AW = 10,
    parameter int LEN_W   = 8
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [SRAM_AW-1:0] req0_sram_addr,
    input  logic [6:0]         req0_host_addr,
    input  logic [LEN_W-1:0]   req0_len,

    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [SRAM_AW-1:0] req1_sram_addr,
    input  logic [6:0]         req1_host_addr,
    input  logic [LEN_W-1:0]   req1_len,

    output logic               sram_rd_en,
    output logic [SRAM_AW-1:0] sram_rd_addr,
    input  logic [17:0]        sram_rd_data,

    output logic [17:0]        dma_dat_w,
    output logic [6:0]         dma_dat_addr,
    output logic               dma_we,
    input  logic               dma_busy,

    output logic               done,
    output logic               done_id,
    output logic               active,
    output logic [2:0]         state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_CAPTURE = 3'd2,
        S_ISSUE   = 3'd3,
        S_WAIT_HI = 3'd4,
        S_WAIT_LO = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic               rr_ptr;     // requester that wins the next contested grant
    logic               grant_id;   // owner of the burst in flight
    logic [SRAM_AW-1:0] cur_sram;
    logic [6:0]         cur_host;
    logic [LEN_W-1:0]   remaining;

    // Arbitration and the selected command
    logic               arb_id;
    logic               accept;
    logic [SRAM_AW-1:0] acc_sram;
    logic [6:0]         acc_host;
    logic [LEN_W-1:0]   acc_len;
    logic               elem_done;   // engine finished the current element
    logic               last_elem;

    always_comb begin
        arb_id   = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
        // Gated by reset so a requester never sees ready on a cycle whose
        // acceptance the reset would discard.
        accept   = (state == S_IDLE) && (req0_valid || req1_valid) && !reset;
        acc_sram = arb_id ? req1_sram_addr : req0_sram_addr;
        acc_host = arb_id ? req1_host_addr : req0_host_addr;
        acc_len  = arb_id ? req1_len       : req0_len;
    end

    assign elem_done = (state == S_WAIT_LO) && !dma_busy;
    assign last_elem = (remaining == LEN_W'(1));

    // Next-state and combinational outputs
    always_comb begin
        state_nxt    = state;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        sram_rd_en   = 1'b0;
        sram_rd_addr = '0;
        dma_we       = 1'b0;
        done         = 1'b0;
        done_id      = 1'b0;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    req0_ready = !arb_id;
                    req1_ready = arb_id;
                    state_nxt  = (acc_len == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                sram_rd_en   = 1'b1;
                sram_rd_addr = cur_sram;
                state_nxt    = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                // A busy left over from an earlier transfer holds off the start.
                if (!dma_busy) begin
                    dma_we    = 1'b1;
                    state_nxt = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (dma_busy) begin
                    state_nxt = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (!dma_busy) begin
                    state_nxt = last_elem ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                done_id   = grant_id;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            rr_ptr       <= 1'b0;
            grant_id     <= 1'b0;
            cur_sram     <= '0;
            cur_host     <= '0;
            remaining    <= '0;
            dma_dat_w    <= '0;
            dma_dat_addr <= '0;
        end else begin
            state <= state_nxt;

            if (accept) begin
                cur_sram  <= acc_sram;
                cur_host  <= acc_host;
                remaining <= acc_len;
                grant_id  <= arb_id;
                rr_ptr    <= !arb_id;
            end

            // The engine reads data/address late (after busy rises), so these
            // are loaded only here and held untouched through WAIT_LO.
            if (state == S_CAPTURE) begin
                dma_dat_w    <= sram_rd_data;
                dma_dat_addr <= cur_host;
            end

            if (elem_done) begin
                remaining <= remaining - 1'b1;
                if (!last_elem) begin
                    cur_sram <= cur_sram + 1'b1;   // wraps mod 2^SRAM_AW
                    cur_host <= cur_host + 1'b1;   // wraps mod 128
                end
            end
        end
    end

    assign active    = (state != S_IDLE);
    assign state_dbg = state;

endmodule
